branch_pred_ctrl: RTL and testbench
===================================

Name: branch_pred_ctrl

Overview:
- Dynamic branch-prediction controller for the 5-stage MIPS pipeline. Holds a table of 2-bit saturating counters indexed by fetch PC.
- Supplies a taken/not-taken prediction to IF, carries it internally to ID, and compares it with the BEQ outcome resolved in ID.
- Drives redirect/flush on mispredict, updates the table and keeps hit/miss statistics.

Parameters:
- IDX_W, 4, index bits; table depth 2**IDX_W entries, index = pc[IDX_W+1:2]
- CNT_W, 16, width of statistics counters
- INIT_STATE, 2'b01, counter value loaded at reset (weakly not-taken)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  pipeline freeze; holds IF->ID capture and table update
- if_valid  in  1  IF holds a real instruction
- if_pc  in  32  PC of fetched instruction
- if_is_branch  in  1  predecode: fetched opcode == BEQ
- if_pred_taken  out  1  prediction for IF; fetch mux selects branch target when 1
- ext_flush  in  1  IF squash requested by jump logic (J/JAL/JR/JALR in ID)
- id_branch  in  1  Branch control for the instruction in ID
- id_taken  in  1  resolved BEQ outcome in ID
- mispredict  out  1  ID prediction wrong; flush IF
- redirect_taken  out  1  with mispredict: refetch at branch target
- redirect_not_taken  out  1  with mispredict: refetch at branch PC+4
- stat_branches  out  CNT_W  resolved branches, saturating
- stat_misses  out  CNT_W  mispredicts, saturating

Behaviour:
- Reset (async, rst_n=0):
  - all table entries = INIT_STATE
  - id_valid_q=0, id_pred_q=0, id_idx_q=0
  - stat_branches=0, stat_misses=0
  - all combinational outputs evaluate to 0 from this state
- Counter FSM per entry (SNT=00, WNT=01, WT=10, ST=11):
  - taken: increment, saturating at ST
  - not taken: decrement, saturating at SNT
  - predict taken iff state[1]=1
- IF (combinational): if_pred_taken = if_valid & if_is_branch & table[if_pc idx][1].
- IF->ID capture at posedge when stall=0:
  - id_valid_q <= if_valid & if_is_branch & ~mispredict & ~ext_flush
  - id_pred_q <= if_pred_taken
  - id_idx_q <= if_pc idx
- When stall=1, all ID registers hold their values.
- ID (combinational):
  - resolve = id_valid_q & id_branch
  - mispredict = resolve & (id_taken != id_pred_q)
  - redirect_taken = mispredict & id_taken
  - redirect_not_taken = mispredict & ~id_taken
  - outputs stay asserted while stalled with the same ID contents. One-cycle latency from fetch to resolution.
- Update at posedge when resolve & ~stall:
  - table[id_idx_q] steps per the counter FSM
  - stat_branches += 1, saturating at all-ones
  - stat_misses += mispredict, saturating at all-ones
- Table read/write to the same index in the same cycle: IF reads the pre-update value (no bypass).
- id_valid_q=1 with id_branch=0 (predecode/decoder disagreement): no mispredict, no update, no stat change.
- Mispredict and ext_flush in the same cycle: the captured IF slot is squashed once; the flags are ORed.
- Reset mid-operation: table and stats return to reset values immediately; no pending update survives.
- Wrap-around: aliasing PCs share an entry by design; no tag check.

Decomposition:
- Shared package:
  - counter state constants SNT/WNT/WT/ST
  - OPC_BEQ = 6'h04, also used by the IF predecoder and control unit
- Sub-module sat_counter2: 2-bit saturating FSM (state in, taken in, next out).
  - instantiated once on the update path
  - table is a register array in branch_pred_ctrl

Test Plan:
- Reset → if_pc=0x40, if_valid=1, if_is_branch=1 → if_pred_taken=0 (entry 01), all stats 0.
- Branch at 0x40 resolved taken twice (id_taken=1), no stall:
  - first resolve: mispredict=1, redirect_taken=1; entry → 10
  - second fetch: if_pred_taken=1, resolve gives mispredict=0; entry → 11
  - stat_branches=2, stat_misses=1
- Entry at 11, then three not-taken resolutions → entry 10, 01, 00. Mispredict pulses 1, 1, 0; redirect_not_taken matches. A fourth not-taken keeps 00.
- stall=1 for 3 cycles with a mispredicting branch in ID:
  - mispredict held for all 3 cycles
  - table and stats unchanged until the stall drops, then a single update
- Mispredict while IF holds a branch at another PC → next cycle id_valid_q=0, mispredict=0, no update for the squashed branch. Repeat with ext_flush=1 → same result.
- Preload stat_misses to 0xFFFF via a long miss sequence → further misses keep 0xFFFF. Asserting rst_n=0 mid-sequence clears table to 01 and stats to 0 without a clock edge.

Source files
------------

// File: rtl/branch_pred_ctrl_pkg.sv
// Shared branch-prediction definitions.
// Counter state encodings, BEQ opcode and small helpers.
package branch_pred_ctrl_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctrState_e;

  localparam logic [5:0] OPC_BEQ = 6'h04;

  // MSB of a 2-bit counter is the taken vote
  function automatic logic predBit(
    input logic [1:0] s
  );
    return s[1];
  endfunction

endpackage

// File: rtl/branch_pred_ctrl_sat.sv
// 2-bit saturating branch counter step.
// Ports: state (current), taken (outcome), nextState (stepped value).
module sat_counter2
  import branch_pred_ctrl_pkg::*;
(
  input  logic [1:0] state,
  input  logic       taken,
  output logic [1:0] nextState
);

  always_comb begin
    nextState = state;
    unique case (ctrState_e'(state))
      SNT: nextState = taken ? WNT : SNT;
      WNT: nextState = taken ? WT  : SNT;
      WT:  nextState = taken ? ST  : WNT;
      ST:  nextState = taken ? ST  : WT;
      default: nextState = state;
    endcase
  end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Dynamic BEQ predictor: counter table, IF->ID tracking, stats.
// Ports: IF (if_*), ID resolve (id_*), redirect/flush, statistics.
module branch_pred_ctrl
  import branch_pred_ctrl_pkg::*;
#(
  parameter int         IDX_W      = 4,
  parameter int         CNT_W      = 16,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic             if_is_branch,
  output logic             if_pred_taken,
  input  logic             ext_flush,
  input  logic             id_branch,
  input  logic             id_taken,
  output logic             mispredict,
  output logic             redirect_taken,
  output logic             redirect_not_taken,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_misses
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       predTable [DEPTH];
  logic [IDX_W-1:0] ifIdx;
  logic             ifPredRaw;

  logic             idValidQ;
  logic             idPredQ;
  logic [IDX_W-1:0] idIdxQ;

  logic             resolve;
  logic             doUpdate;
  logic             squash;
  logic [1:0]       ctrCur;
  logic [1:0]       ctrNext;

  logic             unusedPcBits;

  // Word-aligned PC; upper bits alias freely, no tag
  assign ifIdx = if_pc[IDX_W+1:2];
  assign unusedPcBits =
    ^{if_pc[31:IDX_W+2], if_pc[1:0]};

  // IF reads the table before any same-cycle write
  assign ifPredRaw = predBit(predTable[ifIdx]);
  assign if_pred_taken =
    if_valid & if_is_branch & ifPredRaw;

  assign resolve  = idValidQ & id_branch;
  assign doUpdate = resolve & ~stall;

  assign mispredict =
    resolve & (id_taken != idPredQ);
  assign redirect_taken     = mispredict & id_taken;
  assign redirect_not_taken = mispredict & ~id_taken;

  // Either flush source kills the slot entering ID
  assign squash = mispredict | ext_flush;

  assign ctrCur = predTable[idIdxQ];

  sat_counter2 u_ctr (
    .state     (ctrCur),
    .taken     (id_taken),
    .nextState (ctrNext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        predTable[i] <= INIT_STATE;
      end
    end else if (doUpdate) begin
      predTable[idIdxQ] <= ctrNext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idValidQ <= 1'b0;
      idPredQ  <= 1'b0;
      idIdxQ   <= '0;
    end else if (!stall) begin
      idValidQ <= if_valid & if_is_branch & ~squash;
      idPredQ  <= if_pred_taken;
      idIdxQ   <= ifIdx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches <= '0;
      stat_misses   <= '0;
    end else if (doUpdate) begin
      if (stat_branches != CNT_MAX) begin
        stat_branches <= stat_branches + CNT_ONE;
      end
      if (mispredict && stat_misses != CNT_MAX) begin
        stat_misses <= stat_misses + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Self-checking bench for branch_pred_ctrl.
// Behavioural model + per-cycle compare + directed literal checks.
module tb_branch_pred_ctrl;

  localparam int CW   = 10;
  localparam int SMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          stall = 1'b0;
  logic          if_valid = 1'b0;
  logic [31:0]   if_pc = '0;
  logic          if_is_branch = 1'b0;
  logic          ext_flush = 1'b0;
  logic          id_branch = 1'b0;
  logic          id_taken = 1'b0;
  logic          if_pred_taken;
  logic          mispredict;
  logic          redirect_taken;
  logic          redirect_not_taken;
  logic [CW-1:0] stat_branches;
  logic [CW-1:0] stat_misses;

  branch_pred_ctrl #(
    .IDX_W      (4),
    .CNT_W      (CW),
    .INIT_STATE (2'b01)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .stall              (stall),
    .if_valid           (if_valid),
    .if_pc              (if_pc),
    .if_is_branch       (if_is_branch),
    .if_pred_taken      (if_pred_taken),
    .ext_flush          (ext_flush),
    .id_branch          (id_branch),
    .id_taken           (id_taken),
    .mispredict         (mispredict),
    .redirect_taken     (redirect_taken),
    .redirect_not_taken (redirect_not_taken),
    .stat_branches      (stat_branches),
    .stat_misses        (stat_misses)
  );

  always #5 clk = ~clk;

  int nChk = 0;
  int nFail = 0;

  // Model: counters as integers 0..3, one pending ID slot
  int tbl [16];
  int mV, mP, mI, mB, mM;

  function automatic int eIdx();
    return int'((if_pc >> 2) % 16);
  endfunction

  function automatic int ePred();
    return (if_valid && if_is_branch && tbl[eIdx()] >= 2) ? 1 : 0;
  endfunction

  function automatic int eRes();
    return (mV != 0 && id_branch) ? 1 : 0;
  endfunction

  function automatic int eMis();
    return (eRes() != 0 && int'(id_taken) != mP) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) tbl[i] <= 1;
      mV <= 0; mP <= 0; mI <= 0; mB <= 0; mM <= 0;
    end else if (!stall) begin
      if (eRes() != 0) begin
        if (id_taken) tbl[mI] <= (tbl[mI] == 3) ? 3 : tbl[mI] + 1;
        else          tbl[mI] <= (tbl[mI] == 0) ? 0 : tbl[mI] - 1;
        mB <= (mB == SMAX) ? SMAX : mB + 1;
        if (eMis() != 0) mM <= (mM == SMAX) ? SMAX : mM + 1;
      end
      mV <= (if_valid && if_is_branch && eMis() == 0 && !ext_flush) ? 1 : 0;
      mP <= ePred();
      mI <= eIdx();
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    nChk++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("if_pred_taken", 32'(if_pred_taken), 32'(ePred()));
    chk("mispredict", 32'(mispredict), 32'(eMis()));
    chk("redirect_taken", 32'(redirect_taken),
        32'((eMis() != 0 && id_taken) ? 1 : 0));
    chk("redirect_not_taken", 32'(redirect_not_taken),
        32'((eMis() != 0 && !id_taken) ? 1 : 0));
    chk("stat_branches", 32'(stat_branches), 32'(mB));
    chk("stat_misses", 32'(stat_misses), 32'(mM));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setIn(input logic v, input logic [31:0] pc,
                       input logic br, input logic fl, input logic idb,
                       input logic idt, input logic st);
    if_valid = v; if_pc = pc; if_is_branch = br; ext_flush = fl;
    id_branch = idb; id_taken = idt; stall = st;
  endtask

  task automatic fetchResolve(input logic [31:0] pc, input logic tk,
                              input logic expMis);
    setIn(1, pc, 1, 0, 0, 0, 0);
    cyc();
    setIn(0, 0, 0, 0, 1, tk, 0);
    #1;
    chk("fr_mispredict", 32'(mispredict), 32'(expMis));
    chk("fr_redir_nt", 32'(redirect_not_taken), 32'(expMis & ~tk));
    chk("fr_redir_t", 32'(redirect_taken), 32'(expMis & tk));
    cyc();
  endtask

  task automatic chkStats(input int b, input int m);
    chk("lit_branches", 32'(stat_branches), 32'(b));
    chk("lit_misses", 32'(stat_misses), 32'(m));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state, first fetch of 0x40
    setIn(1, 32'h40, 1, 0, 0, 0, 0);
    #1;
    chk("rst_pred", 32'(if_pred_taken), 0);
    chk("rst_mis", 32'(mispredict), 0);
    chkStats(0, 0);
    cyc();

    // First resolve taken: mispredict, entry -> 10, refetch squashed
    setIn(1, 32'h40, 1, 0, 1, 1, 0);
    #1;
    chk("t1_mis", 32'(mispredict), 1);
    chk("t1_rt", 32'(redirect_taken), 1);
    chk("t1_rnt", 32'(redirect_not_taken), 0);
    cyc();

    setIn(1, 32'h40, 1, 0, 0, 0, 0);
    #1;
    chk("t2_pred", 32'(if_pred_taken), 1);
    chkStats(1, 1);
    cyc();

    setIn(0, 0, 0, 0, 1, 1, 0);
    #1;
    chk("t2_mis", 32'(mispredict), 0);
    cyc();
    chkStats(2, 1);

    // 11 -> 10 -> 01 -> 00 -> 00, then back up
    fetchResolve(32'h40, 0, 1);
    fetchResolve(32'h40, 0, 1);
    fetchResolve(32'h40, 0, 0);
    fetchResolve(32'h40, 0, 0);
    fetchResolve(32'h40, 1, 1);
    fetchResolve(32'h40, 1, 1);
    chkStats(8, 5);

    // Stall with mispredicting branch in ID (0x80 aliases 0x40 at 10)
    setIn(1, 32'h80, 1, 0, 0, 0, 0);
    cyc();
    setIn(0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_mis", 32'(mispredict), 1);
      chk("stall_rnt", 32'(redirect_not_taken), 1);
      chkStats(8, 5);
      cyc();
    end
    setIn(0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("unstall_mis", 32'(mispredict), 1);
    cyc();
    chkStats(9, 6);
    chk("post_stall_mis", 32'(mispredict), 0);

    // Mispredict squashes the branch fetched alongside (entry 0 = 01)
    setIn(1, 32'h40, 1, 0, 0, 0, 0);
    cyc();
    setIn(1, 32'h44, 1, 0, 1, 1, 0);
    #1;
    chk("sq_mis", 32'(mispredict), 1);
    cyc();
    setIn(0, 0, 0, 0, 1, 1, 0);
    #1;
    chk("sq_next_mis", 32'(mispredict), 0);
    cyc();
    chkStats(10, 7);

    // ext_flush squashes the same way
    setIn(1, 32'h44, 1, 1, 0, 0, 0);
    cyc();
    setIn(0, 0, 0, 0, 1, 1, 0);
    #1;
    chk("xf_mis", 32'(mispredict), 0);
    cyc();
    chkStats(10, 7);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      setIn($urandom_range(0, 9) < 8,
            32'($urandom_range(0, 63)) << 2,
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) < 8,
            1'($urandom),
            $urandom_range(0, 9) < 2);
      cyc();
    end

    // Drive every resolve against the model's captured prediction
    setIn(0, 0, 0, 0, 0, 0, 0);
    cyc();
    for (int n = 0; n < SMAX + 20; n++) begin
      setIn(1, 32'h48, 1, 0, 0, 0, 0);
      cyc();
      setIn(0, 0, 0, 0, 1, (mP == 0), 0);
      cyc();
    end
    chkStats(SMAX, SMAX);
    setIn(1, 32'h48, 1, 0, 0, 0, 0);
    cyc();
    setIn(0, 0, 0, 0, 1, (mP == 0), 0);
    #1;
    chk("sat_mis", 32'(mispredict), 1);
    cyc();
    chkStats(SMAX, SMAX);

    // Async reset mid-resolve: no clock edge needed
    setIn(1, 32'h48, 1, 0, 0, 0, 0);
    cyc();
    setIn(0, 0, 0, 0, 1, (mP == 0), 0);
    #1;
    chk("pre_rst_mis", 32'(mispredict), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mis_async", 32'(mispredict), 0);
    chkStats(0, 0);
    for (int i = 0; i < 16; i++) begin
      setIn(1, 32'(i) << 2, 1, 0, 0, 0, 0);
      #1;
      chk("rst_tbl", 32'(if_pred_taken), 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    setIn(0, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc();
    chkStats(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChk, nFail);
    $finish;
  end

endmodule
